// File: rtl/hram_uart_cmd_pkg.sv
// Shared definitions for the HyperRAM serial command engine.
// Holds command codes, frame/response sizes and the FSM state encodings
// used by hram_uart_cmd, hram_resp_ser and their testbench.
package hram_uart_cmd_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned FRAME_BYTES = 5;
    localparam int unsigned RESP_BYTES  = 4;
    localparam int unsigned FRAME_W     = FRAME_BYTES * BYTE_W;
    localparam int unsigned TMO_W       = 24;

    // Command byte codes (first byte of a frame)
    localparam logic [7:0] CMD_ADDR     = 8'h01;
    localparam logic [7:0] CMD_LOAD     = 8'h02;
    localparam logic [7:0] CMD_WRITE    = 8'h03;
    localparam logic [7:0] CMD_READ     = 8'h04;
    localparam logic [7:0] CMD_READ_REQ = 8'h05;
    localparam logic [7:0] CMD_COUNT    = 8'h06;
    localparam logic [7:0] CMD_CONST    = 8'h07;

    // Command engine states; TX_LOAD/TX_WAIT live inside the serializer
    typedef enum logic [2:0] {
        ST_RX        = 3'd0,
        ST_EXEC      = 3'd1,
        ST_WAIT_IDLE = 3'd2,
        ST_REQ       = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_TX        = 3'd5
    } state_e;

    // Response serializer states
    typedef enum logic [1:0] {
        SER_IDLE    = 2'd0,
        SER_TX_LOAD = 2'd1,
        SER_TX_WAIT = 2'd2
    } ser_state_e;

endpackage

// File: rtl/hram_resp_ser.sv
// Response serializer: sends a 32-bit response as 4 bytes, MSB first, to uart_tx.
// Ports: clk, rstn        - clock, async active-low reset
//        load, resp       - 1-cycle request to send resp
//        tx_ready         - uart_tx idle
//        tx_start,tx_data - uart_tx start strobe and byte (held until next start)
//        done             - 1-cycle pulse after the 4th byte has been accepted
module hram_resp_ser
    import hram_uart_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [DATA_W-1:0] resp,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    output logic              done
);

    ser_state_e        state;
    logic [DATA_W-1:0] shreg;
    logic [1:0]        sent;
    logic              seen_low;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= SER_IDLE;
            shreg    <= '0;
            sent     <= '0;
            seen_low <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                SER_IDLE: begin
                    if (load) begin
                        shreg <= resp;
                        sent  <= '0;
                        // Start straight from the load to keep rcv->tx_start at 3 cycles
                        if (tx_ready) begin
                            tx_data  <= resp[DATA_W-1 -: BYTE_W];
                            tx_start <= 1'b1;
                            seen_low <= 1'b0;
                            state    <= SER_TX_WAIT;
                        end else begin
                            state <= SER_TX_LOAD;
                        end
                    end
                end
                SER_TX_LOAD: begin
                    if (tx_ready) begin
                        tx_data  <= shreg[DATA_W-1 -: BYTE_W];
                        tx_start <= 1'b1;
                        seen_low <= 1'b0;
                        state    <= SER_TX_WAIT;
                    end
                end
                SER_TX_WAIT: begin
                    // uart_tx drops ready a little after start; a byte is accepted on fall-then-rise
                    if (!tx_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        shreg <= {shreg[DATA_W-BYTE_W-1:0], BYTE_W'(0)};
                        sent  <= sent + 2'd1;
                        if (sent == 2'(RESP_BYTES - 1)) begin
                            done  <= 1'b1;
                            state <= SER_IDLE;
                        end else begin
                            state <= SER_TX_LOAD;
                        end
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hram_uart_cmd.sv
// Serial command engine between uart_rx/uart_tx and hyper_xface.
// Assembles 5-byte frames (cmd, data MSB..LSB), executes the command,
// drives HyperRAM requests and returns a 4-byte response per frame.
// Ports: clk, rstn                 - clock, async active-low reset
//        rcv, rx_data              - uart_rx byte strobe and byte
//        tx_start, tx_data, tx_ready - uart_tx handshake
//        addr, wr_d, wr_req, rd_req  - hyper_xface request side
//        rd_d, rd_rdy, busy          - hyper_xface response side
//        frame_drop                - pulse when a byte or partial frame is discarded
module hram_uart_cmd
    import hram_uart_cmd_pkg::*;
#(
    parameter logic [TMO_W-1:0]  TIMEOUT_CYC = 24'd1_200_000,
    parameter logic [DATA_W-1:0] CONST_VAL   = 32'd259
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rcv,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] wr_d,
    output logic              wr_req,
    output logic              rd_req,
    input  logic [DATA_W-1:0] rd_d,
    input  logic              rd_rdy,
    input  logic              busy,
    output logic              frame_drop
);

    state_e             state;
    logic [FRAME_W-1:0] frame;
    logic [2:0]         byte_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [DATA_W-1:0]  ram_data;
    logic [DATA_W-1:0]  count;
    logic [DATA_W-1:0]  resp;
    logic               is_wr;
    logic               seen_busy;
    logic               load;
    logic               ser_done;

    logic [BYTE_W-1:0]  cmd;
    logic [DATA_W-1:0]  data;

    assign cmd  = frame[FRAME_W-1 -: BYTE_W];
    assign data = frame[DATA_W-1:0];

    // Frame assembly, command execution and HyperRAM handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_RX;
            frame      <= '0;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            addr       <= '0;
            wr_d       <= '0;
            ram_data   <= '0;
            count      <= '0;
            resp       <= '0;
            is_wr      <= 1'b0;
            seen_busy  <= 1'b0;
            wr_req     <= 1'b0;
            rd_req     <= 1'b0;
            load       <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            wr_req     <= 1'b0;
            rd_req     <= 1'b0;
            load       <= 1'b0;
            frame_drop <= 1'b0;

            // Bytes arriving while a frame is being processed are discarded
            if (state != ST_RX) begin
                tmo_cnt <= '0;
                if (rcv) begin
                    frame_drop <= 1'b1;
                end
            end

            case (state)
                ST_RX: begin
                    if (rcv) begin
                        frame   <= {frame[FRAME_W-BYTE_W-1:0], rx_data};
                        tmo_cnt <= '0;
                        if (byte_cnt == 3'(FRAME_BYTES - 1)) begin
                            byte_cnt <= '0;
                            state    <= ST_EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if (byte_cnt == 3'd0) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TIMEOUT_CYC - TMO_W'(1)) begin
                        byte_cnt   <= '0;
                        tmo_cnt    <= '0;
                        frame_drop <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_EXEC: begin
                    load  <= 1'b1;
                    state <= ST_TX;
                    case (cmd)
                        CMD_ADDR: begin
                            addr <= data;
                            resp <= data;
                        end
                        CMD_LOAD: begin
                            wr_d <= data;
                            resp <= data;
                        end
                        CMD_WRITE: begin
                            resp  <= DATA_W'(3);
                            is_wr <= 1'b1;
                            load  <= 1'b0;
                            state <= ST_WAIT_IDLE;
                        end
                        CMD_READ:  resp <= ram_data;
                        CMD_READ_REQ: begin
                            resp  <= DATA_W'(5);
                            is_wr <= 1'b0;
                            load  <= 1'b0;
                            state <= ST_WAIT_IDLE;
                        end
                        CMD_COUNT: begin
                            resp  <= count;
                            count <= count + DATA_W'(1);
                        end
                        CMD_CONST: resp <= CONST_VAL;
                        default:   resp <= '1;
                    endcase
                end
                ST_WAIT_IDLE: begin
                    if (!busy) begin
                        wr_req <= is_wr;
                        rd_req <= !is_wr;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // busy may already rise while the request is on the bus
                    seen_busy <= busy;
                    state     <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (is_wr) begin
                        if (busy) begin
                            seen_busy <= 1'b1;
                        end else if (seen_busy) begin
                            load  <= 1'b1;
                            state <= ST_TX;
                        end
                    end else if (rd_rdy) begin
                        // Read completes on rd_rdy only, so a coincident busy fall is not counted twice
                        ram_data <= rd_d;
                        load     <= 1'b1;
                        state    <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (ser_done) begin
                        state <= ST_RX;
                    end
                end
                default: state <= ST_RX;
            endcase
        end
    end

    hram_resp_ser u_resp_ser (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .resp     (resp),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .done     (ser_done)
    );

endmodule
